// File: rtl/age_ordered_pool_arbiter.sv
// Age-ordered arbiter locking a pool of shared units to requesting ports.
// Oldest eligible requesters receive the lowest-index idle units; long holds are evicted.
module age_ordered_pool_arbiter #(
  parameter int unsigned NUM_PORTS  = 8,
  parameter int unsigned NUM_UNITS  = 8,
  parameter int unsigned ID_WIDTH   = 16,
  parameter int unsigned HOLD_LIMIT = 64,
  localparam int unsigned UNIT_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*ID_WIDTH-1:0] req_id,
  input  logic                          flush,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [NUM_PORTS*UNIT_W-1:0]   grant_unit,
  output logic [NUM_UNITS-1:0]          unit_busy,
  output logic [NUM_PORTS-1:0]          timeout_err
);

  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W  = (HOLD_LIMIT > 1) ? $clog2(HOLD_LIMIT) : 1;
  localparam int unsigned IDX_W  = $clog2(NUM_PORTS + NUM_UNITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_LIMIT - 1);

  logic [NUM_UNITS-1:0] busy_q, busy_d;
  logic [PORT_W-1:0]    owner_q [NUM_UNITS];
  logic [PORT_W-1:0]    owner_d [NUM_UNITS];
  logic [CNT_W-1:0]     cnt_q   [NUM_UNITS];
  logic [CNT_W-1:0]     cnt_d   [NUM_UNITS];
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [NUM_PORTS-1:0] evicted_q, evicted_d;
  logic [NUM_PORTS-1:0] terr_q, terr_d;
  logic [UNIT_W-1:0]    gu_q [NUM_PORTS];
  logic [UNIT_W-1:0]    gu_d [NUM_PORTS];

  logic [ID_WIDTH-1:0]  id_c   [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig_c;
  logic [IDX_W-1:0]     rank_c [NUM_PORTS];
  logic [IDX_W-1:0]     idle_idx_c;
  logic                 found_c;

  // Wrap-safe age compare: a is older when (a - b) is negative as a signed value.
  function automatic logic is_older(input logic [ID_WIDTH-1:0] id_a,
                                    input logic [ID_WIDTH-1:0] id_b,
                                    input logic                a_lower_idx);
    logic [ID_WIDTH-1:0] diff;
    diff = id_a - id_b;
    if (diff == '0) return a_lower_idx;
    return diff[ID_WIDTH-1];
  endfunction

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
    assign id_c[gp] = req_id[gp*ID_WIDTH +: ID_WIDTH];
    assign grant_unit[gp*UNIT_W +: UNIT_W] = gu_q[gp];
  end

  assign elig_c      = req_valid & ~grant_q & ~evicted_q;
  assign grant       = grant_q;
  assign unit_busy   = busy_q;
  assign timeout_err = terr_q;

  // Rank of each eligible port = number of eligible ports older than it.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rank_c[p] = '0;
      for (int unsigned q = 0; q < NUM_PORTS; q++) begin
        if (q != p && elig_c[q] && is_older(id_c[q], id_c[p], q < p)) begin
          rank_c[p] = rank_c[p] + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    busy_d     = busy_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    evicted_d  = evicted_q;
    terr_d     = terr_q;
    gu_d       = gu_q;
    idle_idx_c = '0;
    found_c    = 1'b0;

    if (flush) begin
      busy_d    = '0;
      grant_d   = '0;
      evicted_d = '0;
      for (int unsigned u = 0; u < NUM_UNITS; u++) cnt_d[u] = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) gu_d[p] = '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (!req_valid[p]) evicted_d[p] = 1'b0;
      end

      // Release on dropped request, evict on expired hold, otherwise age the lock.
      for (int unsigned u = 0; u < NUM_UNITS; u++) begin
        if (busy_q[u]) begin
          if (!req_valid[owner_q[u]]) begin
            busy_d[u]             = 1'b0;
            cnt_d[u]              = '0;
            grant_d[owner_q[u]]   = 1'b0;
            gu_d[owner_q[u]]      = '0;
          end else if (cnt_q[u] == CNT_MAX) begin
            busy_d[u]             = 1'b0;
            cnt_d[u]              = '0;
            grant_d[owner_q[u]]   = 1'b0;
            gu_d[owner_q[u]]      = '0;
            terr_d[owner_q[u]]    = 1'b1;
            evicted_d[owner_q[u]] = 1'b1;
          end else begin
            cnt_d[u] = cnt_q[u] + CNT_W'(1);
          end
        end
      end

      // The k-th idle unit (current state) goes to the eligible port of rank k.
      for (int unsigned u = 0; u < NUM_UNITS; u++) begin
        if (!busy_q[u]) begin
          found_c = 1'b0;
          for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (!found_c && elig_c[p] && rank_c[p] == idle_idx_c) begin
              found_c    = 1'b1;
              busy_d[u]  = 1'b1;
              owner_d[u] = PORT_W'(p);
              cnt_d[u]   = '0;
              grant_d[p] = 1'b1;
              gu_d[p]    = UNIT_W'(u);
            end
          end
          idle_idx_c = idle_idx_c + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      grant_q   <= '0;
      evicted_q <= '0;
      terr_q    <= '0;
      for (int unsigned u = 0; u < NUM_UNITS; u++) begin
        owner_q[u] <= '0;
        cnt_q[u]   <= '0;
      end
      for (int unsigned p = 0; p < NUM_PORTS; p++) gu_q[p] <= '0;
    end else begin
      busy_q    <= busy_d;
      grant_q   <= grant_d;
      evicted_q <= evicted_d;
      terr_q    <= terr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      gu_q      <= gu_d;
    end
  end

endmodule
